uart_echo_bridge: RTL and testbench
===================================

// Module: uart_echo_bridge
// PURPOSE
//  Buffered, fully synchronous loopback controller between the UART RX/TX core and the system.
//  Pulls received words from the core using the RX_SR/RDEN/RDR handshake and stores them in a
//  DEPTH-entry FIFO. Drains the FIFO into the core using the TDR/LOCK_TDR/TX_TC handshake.
//  Replaces hand-built echo glue (derived clocks, edge-latched TDR) with one clock domain.
// PARAMETERS
//  DATA_W       8    word width of RDR/TDR/FIFO
//  DEPTH        16   FIFO entries, power of 2, >=2; AW = $clog2(DEPTH)
//  RD_PULSE_CYC 4    CLK cycles RDEN is held high per read (core needs a slow RDEN edge)
//  RD_WAIT_CYC  8    CLK cycles from RDEN fall to RDR sampling
//  ACK_TMO      4095 max CLK cycles to wait for TX_TC to fall after LOCK_TDR
//  DROP_ON_FULL 1    1: read and discard when FIFO full; 0: stall, word stays in core
// PORTS
//  CLK          in   1        system clock (100 MHz domain)
//  RST_N        in   1        asynchronous active-low reset
//  ECHO_EN      in   1        1: TX drain enabled; 0: FIFO fills, TX FSM holds in T_IDLE
//  FLUSH        in   1        sync clear of FIFO, OVERRUN and TX_ERR (one-cycle pulse suffices)
//  RX_SR        in   1        core has unread RX data
//  RDR          in   DATA_W   core receive data
//  RDEN         out  1        read strobe to core
//  TX_TC        in   1        core transmit complete / idle
//  TDR          out  DATA_W   transmit data to core, stable from T_LOAD until next T_LOAD
//  LOCK_TDR     out  1        one-cycle load strobe to core
//  FIFO_LEVEL   out  AW+1     current occupancy, 0..DEPTH
//  OVERRUN      out  1        sticky: a word was dropped (DROP_ON_FULL=1)
//  TX_ERR       out  1        sticky: ACK_TMO expired
// BEHAVIOUR
//  Reset: RDEN=0, LOCK_TDR=0, TDR=0, FIFO_LEVEL=0, OVERRUN=0, TX_ERR=0, both FSMs idle, pointers 0.
//  RX FSM states: R_IDLE, R_PULSE, R_WAIT, R_CAP.
//   - R_IDLE -> R_PULSE when RX_SR=1 and (not full or DROP_ON_FULL=1).
//   - R_PULSE: RDEN=1 for exactly RD_PULSE_CYC cycles, then R_WAIT.
//   - R_WAIT: RDEN=0 for RD_WAIT_CYC cycles, then R_CAP.
//   - R_CAP (1 cycle): push RDR, or on full discard it and set OVERRUN; then R_IDLE.
//   - Minimum read period is RD_PULSE_CYC + RD_WAIT_CYC + 2 cycles.
//  TX FSM states: T_IDLE, T_LOAD, T_LOCK, T_ACK, T_DONE.
//   - T_IDLE -> T_LOAD when ECHO_EN=1, FIFO not empty and TX_TC=1.
//   - T_LOAD: TDR <= FIFO head; pop.
//   - T_LOCK: LOCK_TDR=1 for one cycle (TDR already stable for 1 cycle).
//   - T_ACK: wait TX_TC=0, then T_DONE. After ACK_TMO cycles without it: set TX_ERR, go to T_IDLE; the word is lost.
//   - T_DONE: wait TX_TC=1, then T_IDLE.
//   - Back-to-back word spacing is bounded by the core only.
//  FIFO:
//   - Full = (level==DEPTH) && !pop_this_cycle, so a push and pop in the same cycle always succeed and leave the level unchanged.
//   - Pointers wrap modulo DEPTH. Level arithmetic is AW+1 bits and never exceeds DEPTH.
//   - Ordering is strict FIFO; no word is duplicated.
//  Full with DROP_ON_FULL=0: the RX FSM stays in R_IDLE and RDEN stays 0 until a slot frees.
//  FLUSH:
//   - Level and pointers go to 0; OVERRUN and TX_ERR are cleared.
//   - A word in R_CAP on the same cycle is discarded.
//   - A TX transfer already past T_LOAD completes normally.
//  ECHO_EN falling mid-transfer: the current word finishes; no new T_LOAD starts.
//  RX_SR and RDR are used as-is. The core drives them from CLK; no synchroniser is added.
// CONFIGURATION
//  UART_ECHO_STATS_EN defined: adds outputs RX_CNT, TX_CNT, DROP_CNT, each 16 bits and saturating at 16'hFFFF.
//   - RX_CNT increments on every R_CAP.
//   - TX_CNT increments on every LOCK_TDR.
//   - DROP_CNT increments on every discard.
//   - All three reset to 0 and clear on FLUSH.
//  Not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 Reset release, RX_SR=0, TX_TC=1 -> RDEN, LOCK_TDR and FIFO_LEVEL stay 0; TDR=0.
//  2 Single word: RDR=8'hA5 with RX_SR pulse, ECHO_EN=1 -> RDEN high 4 cycles; 8 cycles later the word is pushed;
//    TDR=8'hA5 with one LOCK_TDR pulse; level returns 0.
//  3 ECHO_EN=0, 20 words 0x00..0x13, DROP_ON_FULL=1 -> FIFO_LEVEL=16 and OVERRUN=1 (DROP_CNT=4 with stats).
//    Then ECHO_EN=1 -> TDR emits 0x00..0x0F in order.
//  4 Same as 3 with DROP_ON_FULL=0 -> FIFO_LEVEL=16, RDEN held 0, OVERRUN=0.
//    Once the drain starts, words 0x10..0x13 are read and sent in order after 0x0F.
//  5 TX_TC stuck at 1 after LOCK_TDR -> TX_ERR=1 exactly ACK_TMO cycles after T_ACK entry.
//    The next word is then sent normally; FLUSH clears TX_ERR.
//  6 Assert RST_N=0 in R_PULSE and in T_ACK -> RDEN and LOCK_TDR drop immediately (async), level=0.
//    After release, a fresh word round-trips correctly.

Source files
------------

// File: rtl/uart_echo_bridge.sv
// Single-clock UART loopback: pulls words from the RX core into a FIFO and drains them into the TX core.
// Define UART_ECHO_STATS_EN to add the saturating rx_cnt_o / tx_cnt_o / drop_cnt_o counters.
module uart_echo_bridge #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned RD_PULSE_CYC = 4,
  parameter int unsigned RD_WAIT_CYC  = 8,
  parameter int unsigned ACK_TMO      = 4095,
  parameter bit          DROP_ON_FULL = 1'b1,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              echo_en_i,
  input  logic              flush_i,
  input  logic              rx_sr_i,
  input  logic [DATA_W-1:0] rdr_i,
  output logic              rden_o,
  input  logic              tx_tc_i,
  output logic [DATA_W-1:0] tdr_o,
  output logic              lock_tdr_o,
  output logic [AW:0]       fifo_level_o,
  output logic              overrun_o,
  output logic              tx_err_o
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [15:0]       rx_cnt_o,
  output logic [15:0]       tx_cnt_o,
  output logic [15:0]       drop_cnt_o
`endif
);

  localparam int unsigned RMAX = (RD_PULSE_CYC > RD_WAIT_CYC) ? RD_PULSE_CYC : RD_WAIT_CYC;
  localparam int unsigned RCW  = $clog2(RMAX + 1);
  localparam int unsigned TCW  = $clog2(ACK_TMO + 1);

  typedef enum logic [1:0] {R_IDLE, R_PULSE, R_WAIT, R_CAP} rxState_e;
  typedef enum logic [2:0] {T_IDLE, T_LOAD, T_LOCK, T_ACK, T_DONE} txState_e;

  rxState_e          rxState_q;
  txState_e          txState_q;
  logic [RCW-1:0]    rxTimer_q;
  logic [TCW-1:0]    ackTimer_q;
  logic              rden_q;
  logic              lockTdr_q;
  logic [DATA_W-1:0] tdr_q;
  logic              overrun_q;
  logic              txErr_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [AW:0]       level_q, level_d;

  logic push, pop, full, empty, drop, rxStart, ackTimeout;

  // A pop in the same cycle frees a slot, so a simultaneous push never counts as full.
  assign empty      = (level_q == '0);
  assign pop        = (txState_q == T_IDLE) && echo_en_i && !empty && tx_tc_i && !flush_i;
  assign full       = (level_q == (AW+1)'(DEPTH)) && !pop;
  assign push       = (rxState_q == R_CAP) && !full && !flush_i;
  assign drop       = (rxState_q == R_CAP) && full && !flush_i;
  assign rxStart    = rx_sr_i && (!full || DROP_ON_FULL);
  assign ackTimeout = (txState_q == T_ACK) && tx_tc_i && (ackTimer_q == TCW'(ACK_TMO - 1));

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + AW'(1);
      if (pop)  rdPtr_d = rdPtr_q + AW'(1);
      level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wrPtr_q] <= rdr_i;
  end

  // RX side: slow RDEN pulse, settle wait, then a single capture cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxState_q <= R_IDLE;
      rxTimer_q <= '0;
      rden_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (flush_i)   overrun_q <= 1'b0;
      else if (drop) overrun_q <= 1'b1;
      unique case (rxState_q)
        R_IDLE: begin
          if (rxStart) begin
            rxState_q <= R_PULSE;
            rden_q    <= 1'b1;
            rxTimer_q <= '0;
          end
        end
        R_PULSE: begin
          if (rxTimer_q == RCW'(RD_PULSE_CYC - 1)) begin
            rxState_q <= R_WAIT;
            rden_q    <= 1'b0;
            rxTimer_q <= '0;
          end else begin
            rxTimer_q <= rxTimer_q + RCW'(1);
          end
        end
        R_WAIT: begin
          if (rxTimer_q == RCW'(RD_WAIT_CYC - 1)) rxState_q <= R_CAP;
          else rxTimer_q <= rxTimer_q + RCW'(1);
        end
        R_CAP:   rxState_q <= R_IDLE;
        default: rxState_q <= R_IDLE;
      endcase
    end
  end

  // TX side: TDR is loaded on the pop edge so it is stable one cycle before LOCK_TDR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      txState_q  <= T_IDLE;
      tdr_q      <= '0;
      lockTdr_q  <= 1'b0;
      ackTimer_q <= '0;
      txErr_q    <= 1'b0;
    end else begin
      if (flush_i)         txErr_q <= 1'b0;
      else if (ackTimeout) txErr_q <= 1'b1;
      unique case (txState_q)
        T_IDLE: begin
          lockTdr_q <= 1'b0;
          if (pop) begin
            tdr_q     <= mem_q[rdPtr_q];
            txState_q <= T_LOAD;
          end
        end
        T_LOAD: begin
          lockTdr_q <= 1'b1;
          txState_q <= T_LOCK;
        end
        T_LOCK: begin
          lockTdr_q  <= 1'b0;
          ackTimer_q <= '0;
          txState_q  <= T_ACK;
        end
        T_ACK: begin
          if (!tx_tc_i)        txState_q <= T_DONE;
          else if (ackTimeout) txState_q <= T_IDLE;
          else                 ackTimer_q <= ackTimer_q + TCW'(1);
        end
        T_DONE: begin
          if (tx_tc_i) txState_q <= T_IDLE;
        end
        default: txState_q <= T_IDLE;
      endcase
    end
  end

`ifdef UART_ECHO_STATS_EN
  logic [15:0] rxWords_q, txWords_q, dropWords_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxWords_q   <= '0;
      txWords_q   <= '0;
      dropWords_q <= '0;
    end else if (flush_i) begin
      rxWords_q   <= '0;
      txWords_q   <= '0;
      dropWords_q <= '0;
    end else begin
      if ((rxState_q == R_CAP) && (rxWords_q != 16'hFFFF)) rxWords_q <= rxWords_q + 16'd1;
      if (lockTdr_q && (txWords_q != 16'hFFFF))            txWords_q <= txWords_q + 16'd1;
      if (drop && (dropWords_q != 16'hFFFF))               dropWords_q <= dropWords_q + 16'd1;
    end
  end

  assign rx_cnt_o   = rxWords_q;
  assign tx_cnt_o   = txWords_q;
  assign drop_cnt_o = dropWords_q;
`endif

  assign rden_o       = rden_q;
  assign lock_tdr_o   = lockTdr_q;
  assign tdr_o        = tdr_q;
  assign fifo_level_o = level_q;
  assign overrun_o    = overrun_q;
  assign tx_err_o     = txErr_q;

endmodule

// File: tb/tb_uart_echo_bridge.sv
// Bench for uart_echo_bridge: lane 0 drops on full, lane 1 stalls; both share stimulus and a UART core model.
module tb_uart_echo_bridge;

  localparam int DW = 8, DEPTH = 16, RP = 4, RW = 8, TMO = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN, echoEn, flush;
  logic          rxSr[2];
  logic [DW-1:0] rdr[2];
  logic          rden[2];
  logic          txTc[2];
  logic [DW-1:0] tdr[2];
  logic          lockTdr[2];
  logic [4:0]    level[2];
  logic          overrun[2];
  logic          txErr[2];
`ifdef UART_ECHO_STATS_EN
  logic [15:0]   rxCnt[2], txCnt[2], dropCnt[2];
`endif

  logic [DW-1:0] rxMem[2][256];
  int            rxHead[2] = '{0, 0};
  int            rxTail[2] = '{0, 0};
  logic [DW-1:0] txLog[2][256];
  int            txN[2] = '{0, 0};
  bit            stuck[2] = '{0, 0};
  bit            rdenPrev[2] = '{0, 0};
  int            phase[2] = '{0, 0};
  int            dly[2] = '{0, 0};

  logic [DW-1:0] inWords[64];
  logic [DW-1:0] expWords[64];
  int checks = 0, errors = 0;

  for (genvar g = 0; g < 2; g++) begin : gLane
    uart_echo_bridge #(
      .DATA_W(DW), .DEPTH(DEPTH), .RD_PULSE_CYC(RP), .RD_WAIT_CYC(RW),
      .ACK_TMO(TMO), .DROP_ON_FULL(g == 0)
    ) dut (
      .clk_i(clk), .rst_ni(rstN), .echo_en_i(echoEn), .flush_i(flush),
      .rx_sr_i(rxSr[g]), .rdr_i(rdr[g]), .rden_o(rden[g]), .tx_tc_i(txTc[g]),
      .tdr_o(tdr[g]), .lock_tdr_o(lockTdr[g]), .fifo_level_o(level[g]),
      .overrun_o(overrun[g]), .tx_err_o(txErr[g])
`ifdef UART_ECHO_STATS_EN
      , .rx_cnt_o(rxCnt[g]), .tx_cnt_o(txCnt[g]), .drop_cnt_o(dropCnt[g])
`endif
    );
  end

  // UART core model: hands out a queued word on each RDEN rise, logs each LOCK_TDR, then goes busy.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rstN) begin
        rdenPrev[g] = 1'b0;
        phase[g]    = 0;
        txTc[g]     = 1'b1;
        rdr[g]      = '0;
      end else begin
        if (rden[g] && !rdenPrev[g] && rxHead[g] != rxTail[g]) begin
          rdr[g] = rxMem[g][rxHead[g]];
          rxHead[g]++;
        end
        rdenPrev[g] = rden[g];
        if (lockTdr[g]) begin
          txLog[g][txN[g]] = tdr[g];
          txN[g]++;
          if (!stuck[g]) begin
            phase[g] = 1;
            dly[g]   = $urandom_range(1, 3);
          end
        end else if (phase[g] == 1) begin
          dly[g]--;
          if (dly[g] == 0) begin
            txTc[g]  = 1'b0;
            phase[g] = 2;
            dly[g]   = $urandom_range(1, 4);
          end
        end else if (phase[g] == 2) begin
          dly[g]--;
          if (dly[g] == 0) begin
            txTc[g]  = 1'b1;
            phase[g] = 0;
          end
        end
      end
      rxSr[g] = (rxHead[g] != rxTail[g]);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] w);
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      rxMem[g][rxTail[g]] = w;
      rxTail[g]++;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitTx(input int t0, input int t1, input string tag);
    int k = 0;
    while ((txN[0] < t0 || txN[1] < t1) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_done"}, 32'((txN[0] >= t0) && (txN[1] >= t1)), 32'd1);
  endtask

  task automatic pulseFlush();
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  // Reference: words leave in arrival order; only with the drain off and drop-on-full do words beyond DEPTH vanish.
  function automatic int modelAccept(input bit dropOnFull, input bit drainOn, input int n);
    int occ = 0, k = 0;
    for (int i = 0; i < n; i++) begin
      if (drainOn || occ < DEPTH || !dropOnFull) begin
        expWords[k] = inWords[i];
        k++;
        occ++;
      end
    end
    return k;
  endfunction

  task automatic checkLog(input int g, input int base, input int n, input string tag);
    checkOutput($sformatf("%s_count[%0d]", tag, g), 32'(txN[g] - base), 32'(n));
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_word%0d[%0d]", tag, i, g), 32'(txLog[g][base + i]), 32'(expWords[i]));
  endtask

  initial begin
    int base[2];
    int hi, wt, k, n;
    int cnt[2];
    bit seen[2], done[2];

    rstN = 1'b1; echoEn = 1'b0; flush = 1'b0;
    #1 rstN = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("rst_rden[%0d]", g), 32'(rden[g]), 0);
      checkOutput($sformatf("rst_lock[%0d]", g), 32'(lockTdr[g]), 0);
      checkOutput($sformatf("rst_level[%0d]", g), 32'(level[g]), 0);
      checkOutput($sformatf("rst_tdr[%0d]", g), 32'(tdr[g]), 0);
      checkOutput($sformatf("rst_overrun[%0d]", g), 32'(overrun[g]), 0);
      checkOutput($sformatf("rst_txerr[%0d]", g), 32'(txErr[g]), 0);
    end
    @(posedge clk);
    #2 rstN = 1'b1;
    waitCycles(6);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("idle_rden[%0d]", g), 32'(rden[g]), 0);
      checkOutput($sformatf("idle_lock[%0d]", g), 32'(lockTdr[g]), 0);
      checkOutput($sformatf("idle_level[%0d]", g), 32'(level[g]), 0);
      checkOutput($sformatf("idle_tdr[%0d]", g), 32'(tdr[g]), 0);
    end

    // Single word: RDEN width and capture latency, then one echo.
    base = txN;
    applyStimulus(8'hA5);
    k = 0;
    while (!rden[0] && k < 20) begin @(negedge clk); k++; end
    hi = 0;
    while (rden[0] && hi < 50) begin hi++; @(negedge clk); end
    checkOutput("rden_width", 32'(hi), 32'(RP));
    wt = 0;
    while (level[0] == 0 && wt < 50) begin wt++; @(negedge clk); end
    checkOutput("capture_latency", 32'(wt), 32'(RW + 1));
    checkOutput("single_level1", 32'(level[1]), 1);
    echoEn = 1'b1;
    waitTx(base[0] + 1, base[1] + 1, "single");
    waitCycles(20);
    inWords[0] = 8'hA5;
    n = modelAccept(1'b1, 1'b1, 1);
    for (int g = 0; g < 2; g++) begin
      checkLog(g, base[g], n, "single");
      checkOutput($sformatf("single_tdr[%0d]", g), 32'(tdr[g]), 32'hA5);
      checkOutput($sformatf("single_level_end[%0d]", g), 32'(level[g]), 0);
    end

    // Fill with the drain off: lane 0 drops the overflow, lane 1 leaves it in the core.
    echoEn = 1'b0;
    base = txN;
    for (int i = 0; i < 20; i++) begin
      inWords[i] = 8'(i);
      applyStimulus(8'(i));
    end
    waitCycles(340);
    checkOutput("fill_level[0]", 32'(level[0]), 16);
    checkOutput("fill_overrun[0]", 32'(overrun[0]), 1);
    checkOutput("fill_level[1]", 32'(level[1]), 16);
    checkOutput("fill_overrun[1]", 32'(overrun[1]), 0);
    checkOutput("fill_rden[1]", 32'(rden[1]), 0);
    checkOutput("fill_pending[1]", 32'(rxTail[1] - rxHead[1]), 4);
`ifdef UART_ECHO_STATS_EN
    checkOutput("fill_dropcnt[0]", 32'(dropCnt[0]), 4);
    checkOutput("fill_dropcnt[1]", 32'(dropCnt[1]), 0);
`endif
    echoEn = 1'b1;
    waitTx(base[0] + 16, base[1] + 20, "fill");
    waitCycles(30);
    n = modelAccept(1'b1, 1'b0, 20);
    checkLog(0, base[0], n, "fill");
    n = modelAccept(1'b0, 1'b0, 20);
    checkLog(1, base[1], n, "fill");
    checkOutput("fill_drained[0]", 32'(level[0]), 0);
    checkOutput("fill_drained[1]", 32'(level[1]), 0);
    pulseFlush();
    checkOutput("flush_overrun[0]", 32'(overrun[0]), 0);

    // Random words with random arrival gaps and random core busy times.
    base = txN;
    for (int i = 0; i < 24; i++) begin
      inWords[i] = 8'($urandom);
      applyStimulus(inWords[i]);
      waitCycles($urandom_range(0, 20));
    end
    waitTx(base[0] + 24, base[1] + 24, "rand");
    waitCycles(30);
    n = modelAccept(1'b1, 1'b1, 24);
    for (int g = 0; g < 2; g++) begin
      checkLog(g, base[g], n, "rand");
      checkOutput($sformatf("rand_overrun[%0d]", g), 32'(overrun[g]), 0);
    end

    // TX_TC never falls: TX_ERR after exactly TMO cycles in T_ACK.
    stuck = '{1, 1};
    base = txN;
    applyStimulus(8'h5A);
    cnt = '{0, 0}; seen = '{0, 0}; done = '{0, 0};
    k = 0;
    while (!(done[0] && done[1]) && k < TMO + 300) begin
      @(negedge clk);
      k++;
      for (int g = 0; g < 2; g++) begin
        if (!seen[g]) seen[g] = lockTdr[g];
        else if (!done[g]) begin
          if (txErr[g]) done[g] = 1'b1;
          else cnt[g]++;
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("tmo_cycles[%0d]", g), 32'(cnt[g]), 32'(TMO));
      checkOutput($sformatf("tmo_err[%0d]", g), 32'(txErr[g]), 1);
    end
    stuck = '{0, 0};
    applyStimulus(8'hC3);
    waitTx(base[0] + 2, base[1] + 2, "tmo_next");
    waitCycles(20);
    inWords[0] = 8'h5A; inWords[1] = 8'hC3;
    n = modelAccept(1'b1, 1'b1, 2);
    for (int g = 0; g < 2; g++) begin
      checkLog(g, base[g], n, "tmo");
      checkOutput($sformatf("tmo_err_sticky[%0d]", g), 32'(txErr[g]), 1);
    end
    pulseFlush();
    for (int g = 0; g < 2; g++)
      checkOutput($sformatf("flush_txerr[%0d]", g), 32'(txErr[g]), 0);

    // Asynchronous reset while RDEN is high with a word already buffered.
    echoEn = 1'b0;
    applyStimulus(8'h22);
    k = 0;
    while (level[0] == 0 && k < 60) begin @(negedge clk); k++; end
    applyStimulus(8'h11);
    k = 0;
    while (!rden[0] && k < 60) begin @(negedge clk); k++; end
    checkOutput("pulse_seen", 32'(rden[0]), 1);
    #1 rstN = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("arst_rden[%0d]", g), 32'(rden[g]), 0);
      checkOutput($sformatf("arst_level[%0d]", g), 32'(level[g]), 0);
    end
    @(posedge clk);
    #2 rstN = 1'b1;

    // Asynchronous reset while waiting in T_ACK.
    stuck = '{1, 1};
    echoEn = 1'b1;
    base = txN;
    applyStimulus(8'h33);
    k = 0;
    while (txN[0] == base[0] && k < 80) begin @(negedge clk); k++; end
    waitCycles(2);
    #1 rstN = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("arst_ack_lock[%0d]", g), 32'(lockTdr[g]), 0);
      checkOutput($sformatf("arst_ack_tdr[%0d]", g), 32'(tdr[g]), 0);
      checkOutput($sformatf("arst_ack_level[%0d]", g), 32'(level[g]), 0);
    end
    stuck = '{0, 0};
    @(posedge clk);
    #2 rstN = 1'b1;
    waitCycles(3);
    base = txN;
    applyStimulus(8'h3C);
    waitTx(base[0] + 1, base[1] + 1, "post_rst");
    waitCycles(20);
    inWords[0] = 8'h3C;
    n = modelAccept(1'b1, 1'b1, 1);
    for (int g = 0; g < 2; g++) checkLog(g, base[g], n, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
